// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: MEM-stage store/load requests in, data-memory write port and
// status out. The buffer itself uses the slave modport.
interface store_buffer_if #(
    parameter int unsigned PTR_W = 2
);
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [2:0]       st_type;
    logic [31:0]      st_pc;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             drain_hold;
    logic             stall;
    logic             dm_we;
    logic [29:0]      dm_addr;
    logic [31:0]      dm_din;
    logic [2:0]       dm_type;
    logic [31:0]      dm_pc;
    logic             empty;
    logic [PTR_W:0]   count;

    modport master (
        output st_valid, st_addr, st_data, st_type, st_pc, ld_valid, ld_addr, drain_hold,
        input  stall, dm_we, dm_addr, dm_din, dm_type, dm_pc, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_type, st_pc, ld_valid, ld_addr, drain_hold,
        output stall, dm_we, dm_addr, dm_din, dm_type, dm_pc, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// In-order FIFO write buffer between the MEM stage and the data memory write port.
// Drains one store per cycle and stalls loads that hit a pending store's word address.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave bus
);

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [2:0]  typ;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic             full;
    logic             is_empty;
    logic             push;
    logic             pop;
    logic             ld_hit;
    logic [PTR_W-1:0] off;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign is_empty = (count_q == '0);
    assign push     = bus.st_valid & ~full;
    assign pop      = ~is_empty & ~bus.drain_hold;

    // An entry is live when its distance from rd_ptr is below count; covers the full case.
    always_comb begin
        ld_hit = 1'b0;
        off    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (mem_q[i].addr == bus.ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign bus.stall   = (bus.ld_valid & ld_hit) | (bus.st_valid & full);
    assign bus.dm_we   = pop;
    assign bus.dm_addr = mem_q[rd_ptr_q].addr;
    assign bus.dm_din  = mem_q[rd_ptr_q].data;
    assign bus.dm_type = mem_q[rd_ptr_q].typ;
    assign bus.dm_pc   = mem_q[rd_ptr_q].pc;
    assign bus.empty   = is_empty;
    assign bus.count   = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: bus.st_addr[31:2], data: bus.st_data,
                                 typ: bus.st_type, pc: bus.st_pc};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PTR_W + 1)'(1);
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the pipeline MEM stage and the data memory. It sits directly upstream of the data memory's write port.
- Accepts stores from MEM and drains them in order to the data memory, one per cycle.
- Raises a stall for loads whose word address matches a pending store, and for stores arriving while the buffer is full.
- Decouples store issue from the memory write cycle.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_addr  in  32  store byte address; only [31:2] is stored.
- st_data  in  32  store data, already right-aligned.
- st_type  in  3  access size, using the dm_word / dm_halfword / dm_byte encodings from ctrl_encode_def.v.
- st_pc  in  32  PC of the store, carried for trace printing.
- ld_valid  in  1  MEM stage presents a load this cycle.
- ld_addr  in  32  load byte address.
- drain_hold  in  1  inhibits draining this cycle (memory port busy / debug).
- stall  out  1  freeze IF..MEM this cycle.
- dm_we  out  1  data memory write enable.
- dm_addr  out  30  word address [31:2] to data memory.
- dm_din  out  32  write data.
- dm_type  out  3  write size.
- dm_pc  out  32  PC of the draining store.
- empty  out  1  no pending stores.
- count  out  PTR_W+1  number of pending stores.

Behaviour:
- Storage: circular array of DEPTH entries {addr[31:2], data, type, pc}, plus wr_ptr, rd_ptr and count registers. full = (count == DEPTH).
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0. Consequently dm_we=0, empty=1, stall=0 when ld_valid=0 and st_valid=0. Entry contents are don't-care. Reset mid-drain discards all pending stores with no further write.
- push = st_valid & !full. On the clk edge the entry is written at wr_ptr and wr_ptr increments with mod-DEPTH wrap.
- pop = !empty & !drain_hold. dm_we = pop, combinational. dm_addr/dm_din/dm_type/dm_pc are driven combinationally from the entry at rd_ptr. On the clk edge rd_ptr increments with wrap. The data memory captures the write on the same edge.
- Latency: a store pushed at edge N is presented with dm_we=1 during cycle N+1 when the buffer was empty and drain_hold=0. It is written to memory at edge N+1. No same-cycle bypass of a pushed entry to dm_*.
- Simultaneous push and pop: both take effect; count is unchanged. Push while full is refused (st_ready is implicit via stall); a pop in the same cycle does not enable the push.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. empty = (count == 0).
- Load hazard: ld_hit = ld_valid & OR over all valid entries of (entry.addr == ld_addr[31:2]).
  - Comparison is word-granular and conservative; size is ignored.
  - An entry is valid when its index lies in the range rd_ptr..wr_ptr-1 (mod DEPTH), including the entry being popped this cycle.
- stall = ld_hit | (st_valid & full). Purely combinational; no registered state is changed by stall.
- A stalled load re-presents next cycle. The stall clears once the matching entries drain.
- st_valid and ld_valid are mutually exclusive by contract. If both are asserted, the store is processed and ld_hit is still evaluated.
- drain_hold=1: no pop. Pushes continue until full, and then stall asserts for further stores.
- Trace: on each pop, $display("pc = %h: dataaddr = %h, memdata = %h", dm_pc, {dm_addr,2'b00}, dm_din). Simulation only.

Test Plan:
- Reset then idle -> empty=1, count=0, dm_we=0, stall=0. Assert rst mid-operation with 3 entries pending -> count=0 immediately and no dm_we afterward.
- Single store: st_addr=0x0000_0010, data=0xDEADBEEF, type=dm_word, drain_hold=0 -> the next cycle dm_we=1, dm_addr=0x4, dm_din=0xDEADBEEF; the following cycle empty=1.
- Fill: drain_hold=1, push 4 stores to 0x0, 0x4, 0x8, 0xC, then a 5th store -> count=4, stall=1 while st_valid, and the 5th is not accepted. Release hold -> drains in order over 4 cycles with dm_addr 0,1,2,3, and the stall clears once count<4.
- Load hazard: pending byte store to 0x21 and a load of 0x20 -> stall=1 until that entry pops, then stall=0. A load of 0x24 with the same pending store -> stall=0.
- Wrap-around: 10 back-to-back stores with drain_hold=0, with simultaneous push/pop each cycle -> count stays 1, pointers wrap, and all 10 dm writes occur in order with the correct data/type.
- Halfword type passthrough: store type=dm_halfword, data=0x0000ABCD -> dm_type=dm_halfword, dm_din=0x0000ABCD.
